// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement operands, start/busy/done handshake with a held product.
module seq_multiplier #(
    parameter int A_W = 5,
    parameter int B_W = 5
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic                 busy,
    output logic                 done,
    output logic [A_W+B_W-1:0]   product
);
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [A_W-1:0]     r_a_mag;
    logic [B_W-1:0]     r_b_mag;
    logic [P_W-1:0]     r_acc;
    logic [P_W-1:0]     r_product;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_neg;

    logic [A_W-1:0]     w_a_mag;
    logic [B_W-1:0]     w_b_mag;
    logic [P_W-1:0]     w_addend;
    logic [P_W-1:0]     w_acc_sum;
    logic               w_last;

    // Magnitudes are held unsigned, so the most negative input (2^(W-1)) still fits.
    assign w_a_mag   = (signed_mode && a[A_W-1]) ? -a : a;
    assign w_b_mag   = (signed_mode && b[B_W-1]) ? -b : b;
    assign w_addend  = r_b_mag[0] ? (P_W'(r_a_mag) << r_cnt) : '0;
    assign w_acc_sum = r_acc + w_addend;
    assign w_last    = (r_cnt == CNT_W'(B_W - 1));
    assign product   = r_product;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_a_mag    <= '0;
            r_b_mag    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sign_neg <= 1'b0;
            r_product  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_mag    <= w_a_mag;
                        r_b_mag    <= w_b_mag;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_sign_neg <= signed_mode & (a[A_W-1] ^ b[B_W-1]);
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_sum;
                    r_b_mag <= r_b_mag >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Final add folds straight into the result, negated modulo 2^P_W.
                    if (w_last)
                        r_product <= r_sign_neg ? -w_acc_sum : w_acc_sum;
                end
                default: ;
            endcase
        end
    end
endmodule
